multicycle_ctrl: RTL

//  Control FSM for the multicycle MIPS datapath, generation 2. Decodes op/funct, sequences

---
 rtl/multicycle_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multicycle MIPS datapath (gen 2).
// Sequences fetch/decode/execute/mem/writeback and decodes every datapath
// select/enable from the current state plus op/funct/zero/neg/mem_ready.
// Ports:
//   clk, reset (async, active low)
//   op, funct           instruction fields held in the IR
//   zero, neg           ALU flags for branch resolution
//   mem_ready           memory completes the access this cycle
//   pcen, irwrite, memwrite[1:0], regwrite   write strobes
//   dtype, iord, memtoreg, regdst, alusrca, alusrcb[2:0], pcsrc[1:0],
//   alucontrol[3:0], ltype[1:0]              datapath selects
//   state[4:0]          current state (debug)
//   illegal, bus_err    trap cause flags
module multicycle_ctrl #(
  parameter int XLEN     = 64,
  parameter int MEM_WAIT = 1,
  parameter int TIMEOUT  = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       neg,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       irwrite,
  output logic [1:0] memwrite,
  output logic       regwrite,
  output logic       dtype,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [2:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [3:0] alucontrol,
  output logic [1:0] ltype,
  output logic [4:0] state,
  output logic       illegal,
  output logic       bus_err
);
  typedef enum logic [4:0] {
    S_FETCH = 5'd0,  S_DECODE = 5'd1, S_MEMADR = 5'd2, S_MEMRD = 5'd3,
    S_MEMWB = 5'd4,  S_MEMWR  = 5'd5, S_RTEX   = 5'd6, S_RTWB  = 5'd7,
    S_BREX  = 5'd8,  S_IMMEX  = 5'd9, S_IMMWB  = 5'd10, S_JEX  = 5'd11,
    S_TRAP  = 5'd31
  } state_t;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                         OP_BLEZ = 6'h06, OP_BGTZ = 6'h07, OP_ADDI = 6'h08,
                         OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                         OP_LB = 6'h20, OP_LW = 6'h23, OP_LBU = 6'h24,
                         OP_SW = 6'h2B, OP_LD = 6'h37, OP_SD = 6'h3F;
  localparam logic [3:0] ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_AND = 4'b0000,
                         ALU_OR = 4'b0001, ALU_SLT = 4'b0111;
  localparam logic       DW_OK = (XLEN == 64);
  localparam logic [3:0] TO    = 4'(TIMEOUT);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       illegal_q, illegal_d, bus_err_q, bus_err_d;
  logic       pcen_c, irwrite_c, regwrite_c;
  logic [1:0] memwrite_c;
  logic       rdy, is_dw, is_store;

  assign rdy      = (MEM_WAIT != 0) ? mem_ready : 1'b1;
  assign is_dw    = DW_OK && (op == OP_LD || op == OP_SD);
  assign is_store = (op == OP_SW) || (op == OP_SD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      cnt_q     <= 4'd0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = 4'd0;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    pcen_c     = 1'b0;
    irwrite_c  = 1'b0;
    memwrite_c = 2'b00;
    regwrite_c = 1'b0;
    dtype      = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 3'b000;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;
    ltype      = 2'b00;
    case (state_q)
      S_FETCH: begin
        alusrcb   = 3'b001;
        irwrite_c = rdy;
        pcen_c    = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 3'b011;
        case (op)
          OP_LW, OP_SW, OP_LB, OP_LBU:     state_d = S_MEMADR;
          OP_LD, OP_SD: if (DW_OK)         state_d = S_MEMADR;
                        else begin         state_d = S_TRAP; illegal_d = 1'b1; end
          OP_R:                            state_d = S_RTEX;
          OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: state_d = S_BREX;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMMEX;
          OP_J:                            state_d = S_JEX;
          default: begin                   state_d = S_TRAP; illegal_d = 1'b1; end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 3'b010;
        dtype   = is_dw;
        state_d = is_store ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord  = 1'b1;
        dtype = is_dw;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg   = 1'b1;
        dtype      = is_dw;
        ltype      = (op == OP_LB) ? 2'b01 : (op == OP_LBU) ? 2'b10 : 2'b00;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        dtype      = is_dw;
        memwrite_c = is_dw ? 2'b10 : 2'b01;
        if (rdy) state_d = S_FETCH;
      end
      S_RTEX: begin
        alusrca = 1'b1;
        state_d = S_RTWB;
        case (funct)
          6'h20: alucontrol = ALU_ADD;
          6'h22: alucontrol = ALU_SUB;
          6'h24: alucontrol = ALU_AND;
          6'h25: alucontrol = ALU_OR;
          6'h2A: alucontrol = ALU_SLT;
          default: begin state_d = S_TRAP; illegal_d = 1'b1; end
        endcase
      end
      S_RTWB: begin
        regwrite_c = 1'b1;
        regdst     = 1'b1;
        state_d    = S_FETCH;
      end
      S_BREX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen_c     = (op == OP_BEQ  &&  zero) ||
                     (op == OP_BNE  && !zero) ||
                     (op == OP_BLEZ && (zero || neg)) ||
                     (op == OP_BGTZ && !zero && !neg);
        state_d    = S_FETCH;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        case (op)
          OP_ANDI: begin alusrcb = 3'b100; alucontrol = ALU_AND; end
          OP_ORI:  begin alusrcb = 3'b100; alucontrol = ALU_OR;  end
          OP_SLTI: begin alusrcb = 3'b010; alucontrol = ALU_SLT; end
          default: begin alusrcb = 3'b010; alucontrol = ALU_ADD; end
        endcase
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_JEX: begin
        pcsrc   = 2'b10;
        pcen_c  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_TRAP;  // TRAP is sticky until reset
    endcase

    // Memory wait states: the counter runs only while stalled in the same
    // state; when the next stalled cycle would reach TIMEOUT the access is
    // abandoned. A mem_ready on that cycle has already advanced state_d.
    if ((state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR) && !rdy) begin
      if (cnt_q + 4'd1 == TO) begin
        state_d    = S_TRAP;
        bus_err_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Strobes are qualified by reset so an asserted reset kills them in the
  // same cycle, not at the next clock edge.
  assign pcen     = pcen_c & reset;
  assign irwrite  = irwrite_c & reset;
  assign memwrite = memwrite_c & {2{reset}};
  assign regwrite = regwrite_c & reset;
  assign state    = state_q;
  assign illegal  = illegal_q;
  assign bus_err  = bus_err_q;
endmodule
